// File: rtl/sync_fifo_flags_if.sv
// Streaming port bundle for sync_fifo_flags: producer/consumer requests in,
// read data plus occupancy status and error pulses out.
interface sync_fifo_flags_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) ();
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: wen/ren are level requests sampled at every rising edge.
  // A read is taken only when the FIFO is non-empty. A write is taken when
  // the FIFO is not full, or when a read is taken on the same edge. A request
  // that is not taken raises overflow/underflow for one cycle and has no
  // other effect.
  logic             wen;
  logic [WIDTH-1:0] din;
  logic             ren;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wen, din, ren,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wen, din, ren,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO of arbitrary DEPTH with occupancy count, programmable
// almost-full/almost-empty flags, error pulses and registered or FWFT read.
module sync_fifo_flags #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 8,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              reset,
  sync_fifo_flags_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q, count_next;
  logic             full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
  logic [WIDTH-1:0] dout_q;
  logic             rd_acc, wr_acc;

  // Explicit wrap so non-power-of-two depths never alias.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    rd_acc     = bus.ren & ~empty_q;
    wr_acc     = bus.wen & (~full_q | rd_acc);
    count_next = count_q + CW'(wr_acc) - CW'(rd_acc);
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (reset && wr_acc) begin
      mem[wr_ptr] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
        dout_q <= mem[rd_ptr];
      end
      // Flags come from count_next so they track occupancy with no lag.
      count_q <= count_next;
      full_q  <= (count_next == CW'(DEPTH));
      empty_q <= (count_next == '0);
      af_q    <= (count_next >= CW'(AF_THRESH));
      ae_q    <= (count_next <= CW'(AE_THRESH));
      ovf_q   <= bus.wen & ~wr_acc;
      unf_q   <= bus.ren & ~rd_acc;
    end
  end

  // In FWFT mode the head word is shown directly; dout_q holds the last
  // popped head so the output stays stable while empty.
  if (FWFT != 0) begin : g_fwft
    assign bus.dout = empty_q ? dout_q : mem[rd_ptr];
  end else begin : g_reg
    assign bus.dout = dout_q;
  end

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: three configurations share one stimulus stream,
// each checked every cycle against a queue model plus directed literals.
module tb_sync_fifo_flags;
  localparam int NI = 3;
  localparam int D_P  [NI] = '{8, 6, 6};
  localparam int FW_P [NI] = '{0, 0, 1};
  localparam int AF_P [NI] = '{6, 6, 4};
  localparam int AE_P [NI] = '{1, 1, 2};

  logic        clk;
  logic        reset;
  logic        wen, ren;
  logic [63:0] din;
  bit          chk_on;
  int          n_cmp;
  int          n_bad;

  logic [63:0] o_dout  [NI];
  logic [3:0]  o_cnt   [NI];
  logic        o_full  [NI];
  logic        o_empty [NI];
  logic        o_af    [NI];
  logic        o_ae    [NI];
  logic        o_ovf   [NI];
  logic        o_unf   [NI];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input int idx, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL i%0d.%s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int D  = D_P[g];
    localparam int FW = FW_P[g];
    localparam int AF = AF_P[g];
    localparam int AE = AE_P[g];

    sync_fifo_flags_if #(.WIDTH(64), .DEPTH(D)) bus ();

    assign bus.wen = wen;
    assign bus.ren = ren;
    assign bus.din = din;
    assign o_dout[g]  = bus.dout;
    assign o_cnt[g]   = 4'(bus.count);
    assign o_full[g]  = bus.full;
    assign o_empty[g] = bus.empty;
    assign o_af[g]    = bus.almost_full;
    assign o_ae[g]    = bus.almost_empty;
    assign o_ovf[g]   = bus.overflow;
    assign o_unf[g]   = bus.underflow;

    sync_fifo_flags #(
      .WIDTH(64), .DEPTH(D), .FWFT(FW), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    // Behavioural model: a queue of stored words and the last popped word.
    logic [63:0] exp_q[$];
    logic [63:0] last_w;
    bit          e_ovf, e_unf, rd, wr;

    initial begin
      last_w = '0;
      forever begin
        @(posedge clk);
        if (!reset) begin
          exp_q.delete();
          last_w = '0;
          e_ovf  = 1'b0;
          e_unf  = 1'b0;
        end else begin
          rd = ren && (exp_q.size() > 0);
          wr = wen && ((exp_q.size() < D) || rd);
          if (rd) last_w = exp_q.pop_front();
          if (wr) exp_q.push_back(din);
          e_ovf = wen && !wr;
          e_unf = ren && !rd;
        end
      end
    end

    // Compare every cycle on the falling edge.
    initial begin
      forever begin
        @(negedge clk);
        if (chk_on) begin
          check(g, "dout",  o_dout[g],
                ((FW != 0) && (exp_q.size() > 0)) ? exp_q[0] : last_w);
          check(g, "count", 64'(o_cnt[g]),   64'(exp_q.size()));
          check(g, "full",  64'(o_full[g]),  64'(exp_q.size() == D));
          check(g, "empty", 64'(o_empty[g]), 64'(exp_q.size() == 0));
          check(g, "af",    64'(o_af[g]),    64'(exp_q.size() >= AF));
          check(g, "ae",    64'(o_ae[g]),    64'(exp_q.size() <= AE));
          check(g, "ovf",   64'(o_ovf[g]),   64'(e_ovf));
          check(g, "unf",   64'(o_unf[g]),   64'(e_unf));
        end
      end
    end
  end

  // driver: apply inputs for one edge, return 1 time unit after it
  task automatic cycle(input logic w, input logic r, input logic [63:0] d);
    wen = w;
    ren = r;
    din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    chk_on = 1'b0;
    reset  = 1'b0;
    wen    = 1'b0;
    ren    = 1'b0;
    din    = '0;

    // Reset state (DEPTH=8 instance and the others)
    cycle(1'b0, 1'b0, 64'h0);
    cycle(1'b0, 1'b0, 64'h0);
    chk_on = 1'b1;
    check(0, "rst_empty", 64'(o_empty[0]), 64'd1);
    check(0, "rst_count", 64'(o_cnt[0]),   64'd0);
    check(0, "rst_ae",    64'(o_ae[0]),    64'd1);
    check(0, "rst_full",  64'(o_full[0]),  64'd0);
    check(0, "rst_dout",  o_dout[0],       64'd0);
    reset = 1'b1;

    // Fill DEPTH=6 to full, then one rejected write
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b1, 1'b0, 64'(i));
      if (i == 5) check(1, "af_at5", 64'(o_af[1]), 64'd0);
    end
    check(1, "full6",  64'(o_full[1]), 64'd1);
    check(1, "cnt6",   64'(o_cnt[1]),  64'd6);
    check(1, "af6",    64'(o_af[1]),   64'd1);
    check(0, "d8_cnt6_full", 64'(o_full[0]), 64'd0);
    cycle(1'b1, 1'b0, 64'h7);
    check(1, "ovf_pulse", 64'(o_ovf[1]), 64'd1);
    check(1, "ovf_cnt",   64'(o_cnt[1]), 64'd6);
    check(0, "d8_cnt7",   64'(o_cnt[0]), 64'd7);
    cycle(1'b0, 1'b0, 64'h0);
    check(1, "ovf_clear", 64'(o_ovf[1]), 64'd0);

    // Drain in order, then one rejected read
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b0, 1'b1, 64'h0);
      check(1, "rd_order", o_dout[1], 64'(i));
    end
    cycle(1'b0, 1'b1, 64'h0);
    check(1, "unf_pulse", 64'(o_unf[1]), 64'd1);
    check(1, "unf_hold",  o_dout[1],     64'd6);
    check(0, "d8_last",   o_dout[0],     64'd7);

    // FWFT: head visible one cycle after its write, before any ren
    cycle(1'b1, 1'b0, 64'hA5);
    check(2, "fwft_empty", 64'(o_empty[2]), 64'd0);
    check(2, "fwft_head",  o_dout[2],       64'hA5);
    check(1, "reg_nohead", o_dout[1],       64'd6);
    cycle(1'b0, 1'b1, 64'h0);
    check(2, "fwft_pop_empty", 64'(o_empty[2]), 64'd1);
    check(2, "fwft_hold",      o_dout[2],       64'hA5);

    // Full with simultaneous write and read
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 64'h10 + 64'(i));
    cycle(1'b1, 1'b1, 64'h16);
    check(1, "fullrw_full", 64'(o_full[1]), 64'd1);
    check(1, "fullrw_ovf",  64'(o_ovf[1]),  64'd0);
    check(1, "fullrw_cnt",  64'(o_cnt[1]),  64'd6);
    check(1, "fullrw_dout", o_dout[1],      64'h10);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 64'h0);
    check(1, "drain_last", o_dout[1], 64'h16);

    // Empty with simultaneous write and read
    cycle(1'b1, 1'b1, 64'h20);
    check(1, "emptyrw_unf", 64'(o_unf[1]), 64'd1);
    check(1, "emptyrw_cnt", 64'(o_cnt[1]), 64'd1);
    check(1, "emptyrw_dout", o_dout[1],    64'h16);
    cycle(1'b0, 1'b1, 64'h0);
    check(1, "emptyrw_rd", o_dout[1], 64'h20);

    // Wrap: hold count at 3 with continuous write+read
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 64'h30 + 64'(i));
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 64'h40 + 64'(i));
      check(1, "wrap_cnt",  64'(o_cnt[1]), 64'd3);
      check(1, "wrap_dout", o_dout[1],
            (i < 3) ? 64'h30 + 64'(i) : 64'h40 + 64'(i - 3));
    end

    // Reset mid-operation with count 5
    cycle(1'b1, 1'b0, 64'h60);
    cycle(1'b1, 1'b0, 64'h61);
    check(1, "pre_rst_cnt", 64'(o_cnt[1]), 64'd5);
    reset = 1'b0;
    cycle(1'b0, 1'b0, 64'h0);
    reset = 1'b1;
    check(1, "mid_rst_cnt",   64'(o_cnt[1]),   64'd0);
    check(1, "mid_rst_empty", 64'(o_empty[1]), 64'd1);
    check(1, "mid_rst_dout",  o_dout[1],       64'd0);
    cycle(1'b1, 1'b0, 64'h77);
    check(2, "post_rst_fwft", o_dout[2], 64'h77);
    cycle(1'b0, 1'b1, 64'h0);
    check(1, "post_rst_rd", o_dout[1], 64'h77);

    // Random 50/50 traffic checked by the per-cycle compare
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {$urandom(), $urandom()});
    end
    cycle(1'b0, 1'b0, 64'h0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
